// File: rtl/rv_regfile_mp_pkg.sv
// Shared constants and state encoding for the multi-port register file.
package rv_regfile_mp_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_N_READ = 2;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;

endpackage

// File: rtl/rv_regfile_mp_if.sv
// Decode/writeback-side bundle of the multi-port register file.
interface rv_regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int N_READ = 2
);

    logic                     stall_i;
    logic [N_READ*ADDR_W-1:0] rd_addr_i;
    logic [N_READ*DATA_W-1:0] rd_data_o;
    logic [ADDR_W-1:0]        w_addr_i;
    logic [DATA_W-1:0]        w_data_i;
    logic                     w_en_i;
    logic                     ready_o;

    modport master (
        output stall_i,
        output rd_addr_i,
        output w_addr_i,
        output w_data_i,
        output w_en_i,
        input  rd_data_o,
        input  ready_o
    );

    modport slave (
        input  stall_i,
        input  rd_addr_i,
        input  w_addr_i,
        input  w_data_i,
        input  w_en_i,
        output rd_data_o,
        output ready_o
    );

endinterface

// File: rtl/rv_regfile_mp_bank.sv
// One read port / one write port bank with registered read,
// same-address write bypass and held-address write tracking.
module rv_regmem_bank
    import rv_regfile_mp_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              cap_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] w_addr_i,
    input  logic [DATA_W-1:0] w_data_i
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[w_addr_i] <= w_data_i;
        end
    end

    always_comb begin
        raddr_d = raddr_q;
        rdata_d = rdata_q;
        if (flush_i) begin
            raddr_d = '0;
            rdata_d = '0;
        end else if (cap_i) begin
            raddr_d = rd_addr_i;
            if (we_i && w_addr_i == rd_addr_i) begin
                rdata_d = w_data_i;
            end else begin
                rdata_d = mem_q[rd_addr_i];
            end
        end else if (we_i && w_addr_i == raddr_q) begin
            // stalled consumer follows writes to the held entry
            rdata_d = w_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            raddr_q <= '0;
            rdata_q <= '0;
        end else begin
            raddr_q <= raddr_d;
            rdata_q <= rdata_d;
        end
    end

    assign rd_addr_o = raddr_q;
    assign rd_data_o = rdata_q;

endmodule

// File: rtl/rv_regfile_mp.sv
// Multi-read-port register file with post-reset clear sweep
// and stall-aware held read outputs.
module rv_regfile_mp
    import rv_regfile_mp_pkg::*;
#(
    parameter int DATA_W         = RF_DATA_W,
    parameter int ADDR_W         = RF_ADDR_W,
    parameter int N_READ         = RF_N_READ,
    parameter bit ZERO_REG       = 1'b1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    rv_regfile_mp_if.slave     rf
);

    localparam rf_state_e RST_STATE =
        CLEAR_ON_RESET ? RF_CLEAR : RF_RUN;

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    logic              clr;
    logic              run;
    logic              cap_en;
    logic              ext_we;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    logic [N_READ*DATA_W-1:0] rd_all;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RF_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    state_d = RF_RUN;
                end
            end
            RF_RUN: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    assign clr    = (state_q == RF_CLEAR);
    assign run    = (state_q == RF_RUN);
    assign cap_en = run & ~rf.stall_i;

    assign ext_we = run & rf.w_en_i &
                    (!ZERO_REG || rf.w_addr_i != '0);

    // the sweep owns the write port while clearing
    assign we    = ~rst_i & (clr | ext_we);
    assign waddr = clr ? cnt_q : rf.w_addr_i;
    assign wdata = clr ? '0 : rf.w_data_i;

    for (genvar k = 0; k < N_READ; k++) begin : g_bank
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;

        rv_regmem_bank #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .flush_i   (clr),
            .cap_i     (cap_en),
            .rd_addr_i (rf.rd_addr_i[k*ADDR_W +: ADDR_W]),
            .rd_addr_o (ra),
            .rd_data_o (rd),
            .we_i      (we),
            .w_addr_i  (waddr),
            .w_data_i  (wdata)
        );

        assign rd_all[k*DATA_W +: DATA_W] =
            (ZERO_REG && ra == '0) ? '0 : rd;
    end

    assign rf.rd_data_o = rd_all;
    assign rf.ready_o   = run;

endmodule

// File: tb/tb_rv_regfile_mp.sv
// Directed and model-checked bench for rv_regfile_mp in three
// configurations.
module tb_rv_regfile_mp;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    rv_regfile_mp_if #(
        .DATA_W(32), .ADDR_W(5), .N_READ(2)
    ) if0 ();
    rv_regfile_mp_if #(
        .DATA_W(32), .ADDR_W(5), .N_READ(2)
    ) if1 ();
    rv_regfile_mp_if #(
        .DATA_W(64), .ADDR_W(4), .N_READ(3)
    ) if2 ();

    rv_regfile_mp #(
        .DATA_W(32), .ADDR_W(5), .N_READ(2),
        .ZERO_REG(1'b1), .CLEAR_ON_RESET(1'b1)
    ) u0 (.clk_i(clk), .rst_i(rst), .rf(if0));

    rv_regfile_mp #(
        .DATA_W(32), .ADDR_W(5), .N_READ(2),
        .ZERO_REG(1'b0), .CLEAR_ON_RESET(1'b0)
    ) u1 (.clk_i(clk), .rst_i(rst), .rf(if1));

    rv_regfile_mp #(
        .DATA_W(64), .ADDR_W(4), .N_READ(3),
        .ZERO_REG(1'b1), .CLEAR_ON_RESET(1'b1)
    ) u2 (.clk_i(clk), .rst_i(rst), .rf(if2));

    int n_chk = 0;
    int n_err = 0;

    logic [63:0] mem_m [16];
    logic [3:0]  cap_m [3];

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr0(input logic [4:0] a,
                       input logic [31:0] d);
        if0.w_addr_i = a;
        if0.w_data_i = d;
        if0.w_en_i   = 1'b1;
        step(1);
        if0.w_en_i   = 1'b0;
    endtask

    task automatic sweep(input string tag);
        for (int i = 1; i <= 32; i++) begin
            step(1);
            if (i == 1)
                chk({tag, "_u1rdy"}, 64'(if1.ready_o), 64'd1);
            if (i == 5)
                chk({tag, "_rd0"}, 64'(if0.rd_data_o), 64'd0);
            if (i == 15)
                chk({tag, "_u2rdy15"}, 64'(if2.ready_o), 64'd0);
            if (i == 16)
                chk({tag, "_u2rdy16"}, 64'(if2.ready_o), 64'd1);
            if (i == 31)
                chk({tag, "_rdy31"}, 64'(if0.ready_o), 64'd0);
            if (i == 32)
                chk({tag, "_rdy32"}, 64'(if0.ready_o), 64'd1);
        end
    endtask

    logic        r_st;
    logic        r_we;
    logic [3:0]  r_wa;
    logic [63:0] r_wd;
    logic [3:0]  r_ra;

    initial begin
        if0.stall_i = 0; if0.rd_addr_i = '0; if0.w_addr_i = '0;
        if0.w_data_i = '0; if0.w_en_i = 0;
        if1.stall_i = 0; if1.rd_addr_i = '0; if1.w_addr_i = '0;
        if1.w_data_i = '0; if1.w_en_i = 0;
        if2.stall_i = 0; if2.rd_addr_i = '0; if2.w_addr_i = '0;
        if2.w_data_i = '0; if2.w_en_i = 0;

        step(2);
        chk("rst_rdy", 64'(if0.ready_o), 64'd0);
        chk("rst_data", 64'(if0.rd_data_o), 64'd0);
        rst = 1'b0;

        // write attempts during the sweep must be dropped
        if0.w_addr_i = 5'd9;
        if0.w_data_i = 32'h55;
        if0.w_en_i   = 1'b1;
        sweep("clr1");
        if0.w_en_i   = 1'b0;

        for (int a = 0; a < 32; a++) begin
            if0.rd_addr_i = {5'(31 - a), 5'(a)};
            step(1);
            chk($sformatf("zero_p0_r%0d", a),
                64'(if0.rd_data_o[31:0]), 64'd0);
            chk($sformatf("zero_p1_r%0d", 31 - a),
                64'(if0.rd_data_o[63:32]), 64'd0);
        end

        // same-edge write and capture
        if0.rd_addr_i = {5'd0, 5'd5};
        wr0(5'd5, 32'hDEADBEEF);
        chk("bypass", 64'(if0.rd_data_o[31:0]), 64'hDEADBEEF);

        wr0(5'd7, 32'h11);
        wr0(5'd3, 32'h33);
        if0.rd_addr_i = {5'd7, 5'd3};
        step(1);
        chk("hold_p1", 64'(if0.rd_data_o[63:32]), 64'h11);
        chk("hold_p0", 64'(if0.rd_data_o[31:0]), 64'h33);
        if0.stall_i   = 1'b1;
        if0.rd_addr_i = {5'd1, 5'd2};
        wr0(5'd7, 32'h22);
        chk("trk_p1", 64'(if0.rd_data_o[63:32]), 64'h22);
        chk("trk_p0", 64'(if0.rd_data_o[31:0]), 64'h33);
        step(2);
        chk("trk_p1_hold", 64'(if0.rd_data_o[63:32]), 64'h22);
        chk("trk_p0_hold", 64'(if0.rd_data_o[31:0]), 64'h33);
        if0.stall_i = 1'b0;

        wr0(5'd0, 32'hFFFFFFFF);
        if0.rd_addr_i = '0;
        step(1);
        chk("r0_p0", 64'(if0.rd_data_o[31:0]), 64'd0);
        chk("r0_p1", 64'(if0.rd_data_o[63:32]), 64'd0);

        if1.w_addr_i = '0;
        if1.w_data_i = 32'hFFFFFFFF;
        if1.w_en_i   = 1'b1;
        step(1);
        if1.w_en_i    = 1'b0;
        if1.rd_addr_i = '0;
        step(1);
        chk("nz_r0_p0", 64'(if1.rd_data_o[31:0]), 64'hFFFFFFFF);
        chk("nz_r0_p1", 64'(if1.rd_data_o[63:32]), 64'hFFFFFFFF);

        if0.rd_addr_i = {5'd20, 5'd20};
        wr0(5'd20, 32'hAB);
        step(1);
        chk("r20_pre", 64'(if0.rd_data_o[31:0]), 64'hAB);

        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(10);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        sweep("clr2");
        step(1);
        chk("r20_p0", 64'(if0.rd_data_o[31:0]), 64'd0);
        chk("r20_p1", 64'(if0.rd_data_o[63:32]), 64'd0);
        chk("keep_u1_p0", 64'(if1.rd_data_o[31:0]), 64'hFFFFFFFF);
        chk("keep_u1_p1", 64'(if1.rd_data_o[63:32]), 64'hFFFFFFFF);

        for (int i = 0; i < 16; i++) mem_m[i] = '0;
        for (int k = 0; k < 3; k++) cap_m[k] = '0;

        // each port shows the current contents of its captured entry
        for (int n = 0; n < 200; n++) begin
            r_st = ($urandom_range(3) == 0);
            r_we = 1'($urandom_range(1));
            r_wa = 4'($urandom_range(15));
            r_wd = {$urandom, $urandom};
            if2.stall_i  = r_st;
            if2.w_en_i   = r_we;
            if2.w_addr_i = r_wa;
            if2.w_data_i = r_wd;
            for (int k = 0; k < 3; k++) begin
                r_ra = 4'($urandom_range(15));
                if2.rd_addr_i[k*4 +: 4] = r_ra;
                if (!r_st) cap_m[k] = r_ra;
            end
            if (r_we && r_wa != 4'd0) mem_m[r_wa] = r_wd;
            step(1);
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("rnd%0d_p%0d", n, k),
                    if2.rd_data_o[k*64 +: 64], mem_m[cap_m[k]]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
